// File: rtl/loop_controller_pkg.sv
// Shared types and constants for the hardware loop controller.
// Optional macro SENIOR_LC_NESTING_EN selects full nesting depth; otherwise a single loop level.
`include "senior_defines.vh"

package loop_controller_pkg;

    localparam int LC_ADDR_W  = `SENIOR_LC_ADDR_W;
    localparam int LC_CNT_W   = `SENIOR_LC_CNT_W;
    localparam int LC_LEVEL_W = 3;

    typedef enum logic {
        LC_IDLE   = 1'b0,
        LC_ACTIVE = 1'b1
    } lc_state_t;

    // Number of loop entries actually implemented for a requested depth.
    function automatic int lc_eff_depth(input int depth);
`ifdef SENIOR_LC_NESTING_EN
        return depth;
`else
        return (depth > 0) ? 1 : 1;
`endif
    endfunction

endpackage

// File: rtl/loop_controller_if.sv
// Decoder / fetch / flow-control signal bundle of the hardware loop controller.
`include "senior_defines.vh"

interface loop_controller_if
    import loop_controller_pkg::*;
#(
    parameter int nat_w = `SENIOR_NATIVE_WIDTH
);
    logic                  lc_start_i;
    logic [nat_w-1:0]      lc_count_i;
    logic [nat_w-1:0]      lc_start_addr_i;
    logic [nat_w-1:0]      lc_end_addr_i;
    logic [nat_w-1:0]      pc_i;
    logic                  pc_valid_i;
    logic                  lc_clear_i;
    logic                  lc_loopb_req_o;
    logic [nat_w-1:0]      lc_pc_loopb_o;
    logic                  lc_active_o;
    logic [LC_LEVEL_W-1:0] lc_level_o;
    logic                  lc_err_o;

    modport master (
        output lc_start_i, lc_count_i, lc_start_addr_i, lc_end_addr_i,
               pc_i, pc_valid_i, lc_clear_i,
        input  lc_loopb_req_o, lc_pc_loopb_o, lc_active_o, lc_level_o, lc_err_o
    );

    modport slave (
        input  lc_start_i, lc_count_i, lc_start_addr_i, lc_end_addr_i,
               pc_i, pc_valid_i, lc_clear_i,
        output lc_loopb_req_o, lc_pc_loopb_o, lc_active_o, lc_level_o, lc_err_o
    );
endinterface

// File: rtl/loop_controller_stack.sv
// LIFO of loop entries {start, end, remaining}; top entry is readable combinationally.
// Pop and push in one cycle replace the top; decrement applies only to the current top.
`include "senior_defines.vh"

module lc_loop_stack
    import loop_controller_pkg::*;
#(
    parameter int addr_w = LC_ADDR_W,
    parameter int cnt_w  = LC_CNT_W,
    parameter int depth  = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       dec_i,
    input  logic [addr_w-1:0]          push_start_i,
    input  logic [addr_w-1:0]          push_end_i,
    input  logic [cnt_w-1:0]           push_count_i,
    output logic [addr_w-1:0]          top_start_o,
    output logic [addr_w-1:0]          top_end_o,
    output logic [cnt_w-1:0]           top_rem_o,
    output logic [$clog2(depth+1)-1:0] level_o
);
    localparam int LVL_W = $clog2(depth + 1);
    localparam int IDX_W = (depth > 1) ? $clog2(depth) : 1;

    logic [addr_w-1:0] start_mem [depth];
    logic [addr_w-1:0] end_mem   [depth];
    logic [cnt_w-1:0]  rem_mem   [depth];

    logic [LVL_W-1:0] level_reg, level_next;
    logic [IDX_W-1:0] top_idx, wr_idx;
    logic [depth-1:0] wr_slot, dec_slot;
    logic             empty;

    assign empty   = (level_reg == '0);
    assign top_idx = IDX_W'(level_reg - 1'b1);
    // A same-cycle pop frees the top slot, so the new entry overwrites it.
    assign wr_idx  = pop_i ? top_idx : IDX_W'(level_reg);

    for (genvar gi = 0; gi < depth; gi++) begin : g_slot
        assign wr_slot[gi]  = push_i && (wr_idx == IDX_W'(gi));
        assign dec_slot[gi] = dec_i && !empty && (top_idx == IDX_W'(gi));
    end

    always_comb begin
        level_next = level_reg;
        if (clear_i) begin
            level_next = '0;
        end else begin
            case ({push_i, pop_i})
                2'b10:   level_next = level_reg + 1'b1;
                2'b01:   level_next = level_reg - 1'b1;
                default: level_next = level_reg;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            level_reg <= '0;
        end else begin
            level_reg <= level_next;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < depth; i++) begin
            if (wr_slot[i]) begin
                start_mem[i] <= push_start_i;
                end_mem[i]   <= push_end_i;
                rem_mem[i]   <= push_count_i;
            end else if (dec_slot[i]) begin
                rem_mem[i]   <= rem_mem[i] - 1'b1;
            end
        end
    end

    assign top_start_o = empty ? '0 : start_mem[top_idx];
    assign top_end_o   = empty ? '0 : end_mem[top_idx];
    assign top_rem_o   = empty ? '0 : rem_mem[top_idx];
    assign level_o     = level_reg;

endmodule

// File: rtl/senior_defines.vh
// Shared width definitions for the senior core; every loop-controller file includes this.
`ifndef SENIOR_DEFINES_VH
`define SENIOR_DEFINES_VH

`define SENIOR_NATIVE_WIDTH 16
`define SENIOR_LC_ADDR_W    `SENIOR_NATIVE_WIDTH
`define SENIOR_LC_CNT_W     `SENIOR_NATIVE_WIDTH

`endif

// File: rtl/loop_controller.sv
// Zero-overhead hardware loop controller: end-address match, loop-back request, nesting LIFO.
// Define SENIOR_LC_NESTING_EN for lc_depth nesting levels; default build holds a single loop.
`include "senior_defines.vh"

module loop_controller
    import loop_controller_pkg::*;
#(
    parameter int nat_w    = `SENIOR_NATIVE_WIDTH,
    parameter int lc_depth = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    loop_controller_if.slave lc_bus
);
    localparam int EFF_DEPTH = lc_eff_depth(lc_depth);
    localparam int LVL_W     = $clog2(EFF_DEPTH + 1);

    lc_state_t state_reg, state_next;

    logic [nat_w-1:0] top_start, top_end, top_rem;
    logic [LVL_W-1:0] stk_level;

    logic is_active, end_match, last_pass, full;
    logic start_ok, count_zero;
    logic loopb_req, push, pop, dec, err;

    lc_loop_stack #(
        .addr_w (nat_w),
        .cnt_w  (nat_w),
        .depth  (EFF_DEPTH)
    ) u_stack (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .clear_i      (lc_bus.lc_clear_i),
        .push_i       (push),
        .pop_i        (pop),
        .dec_i        (dec),
        .push_start_i (lc_bus.lc_start_addr_i),
        .push_end_i   (lc_bus.lc_end_addr_i),
        .push_count_i (lc_bus.lc_count_i),
        .top_start_o  (top_start),
        .top_end_o    (top_end),
        .top_rem_o    (top_rem),
        .level_o      (stk_level)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg <= LC_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        is_active  = (state_reg == LC_ACTIVE);
        end_match  = is_active && lc_bus.pc_valid_i && (lc_bus.pc_i == top_end);
        last_pass  = (top_rem == nat_w'(1));
        full       = (stk_level == LVL_W'(EFF_DEPTH));
        count_zero = (lc_bus.lc_count_i == '0);

        // Loop-back request follows the current state even when a flush is pending.
        loopb_req  = end_match && !last_pass;
        pop        = end_match && last_pass && !lc_bus.lc_clear_i;
        dec        = end_match && !last_pass && !lc_bus.lc_clear_i;

        start_ok   = lc_bus.lc_start_i && !lc_bus.lc_clear_i && !reset_i;
        err        = start_ok && (count_zero || (full && !pop));
        push       = start_ok && !count_zero && !(full && !pop);

        if (lc_bus.lc_clear_i) begin
            state_next = LC_IDLE;
        end else if (push) begin
            state_next = LC_ACTIVE;
        end else if (pop && (stk_level == LVL_W'(1))) begin
            state_next = LC_IDLE;
        end
    end

    assign lc_bus.lc_loopb_req_o = loopb_req;
    assign lc_bus.lc_pc_loopb_o  = is_active ? top_start : '0;
    assign lc_bus.lc_active_o    = is_active;
    assign lc_bus.lc_level_o     = LC_LEVEL_W'(stk_level);
    assign lc_bus.lc_err_o       = err;

endmodule

// File: tb/tb_loop_controller.sv
// Self-checking bench for loop_controller: directed loop scenarios plus random traffic vs a queue model.
module tb_loop_controller;

    localparam int W = 16;
`ifdef SENIOR_LC_NESTING_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic clk = 1'b0;
    logic reset_i;
    always #5 clk = ~clk;

    loop_controller_if #(.nat_w(W)) bus ();

    loop_controller #(.nat_w(W), .lc_depth(4)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .lc_bus  (bus)
    );

    typedef struct {
        logic [W-1:0] sa;
        logic [W-1:0] ea;
        logic [W-1:0] rem;
    } loop_t;

    loop_t model_q[$];

    int total = 0;
    int bad   = 0;

    logic         obs_loopb;
    logic [W-1:0] obs_pcl;
    logic [2:0]   obs_level;
    logic         obs_err;
    int           peak_level;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive, compare against the model before the edge, then advance the model.
    task automatic cycle(input logic st, input logic [W-1:0] cnt, input logic [W-1:0] sa,
                         input logic [W-1:0] ea, input logic [W-1:0] p, input logic pv,
                         input logic cl, input logic rs);
        logic         exp_act, exp_match, exp_loopb, exp_pop, exp_dec, exp_err, exp_push;
        logic [W-1:0] exp_pcl;
        loop_t        top;
        bus.lc_start_i      = st;
        bus.lc_count_i      = cnt;
        bus.lc_start_addr_i = sa;
        bus.lc_end_addr_i   = ea;
        bus.pc_i            = p;
        bus.pc_valid_i      = pv;
        bus.lc_clear_i      = cl;
        reset_i             = rs;
        @(negedge clk);
        exp_act = (model_q.size() != 0);
        top.sa = '0; top.ea = '0; top.rem = '0;
        if (exp_act) top = model_q[model_q.size()-1];
        exp_match = exp_act && pv && (p == top.ea);
        exp_loopb = exp_match && (top.rem != 1);
        exp_pcl   = exp_act ? top.sa : '0;
        exp_pop   = exp_match && (top.rem == 1) && !cl;
        exp_dec   = exp_match && (top.rem != 1) && !cl;
        exp_err   = st && !cl && !rs && ((cnt == 0) || (model_q.size() >= DEPTH && !exp_pop));
        exp_push  = st && !cl && !rs && !exp_err;
        check_val("loopb_req", bus.lc_loopb_req_o, exp_loopb);
        check_val("pc_loopb", bus.lc_pc_loopb_o, exp_pcl);
        check_val("active", bus.lc_active_o, exp_act);
        check_val("level", bus.lc_level_o, model_q.size());
        check_val("err", bus.lc_err_o, exp_err);
        obs_loopb = bus.lc_loopb_req_o;
        obs_pcl   = bus.lc_pc_loopb_o;
        obs_level = bus.lc_level_o;
        obs_err   = bus.lc_err_o;
        if (int'(obs_level) > peak_level) peak_level = int'(obs_level);
        if (st)
            $display("repeat cnt=%0d start=%h end=%h pc=%h level=%0d err=%0b",
                     cnt, sa, ea, p, obs_level, obs_err);
        @(posedge clk);
        #1;
        if (rs || cl) begin
            model_q.delete();
        end else begin
            if (exp_pop) void'(model_q.pop_back());
            if (exp_dec) begin
                top.rem = top.rem - 1'b1;
                model_q[model_q.size()-1] = top;
            end
            if (exp_push) begin
                loop_t n;
                n.sa = sa; n.ea = ea; n.rem = cnt;
                model_q.push_back(n);
            end
        end
    endtask

    task automatic fetch(input logic [W-1:0] p);
        cycle(1'b0, '0, '0, '0, p, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic nop();
        cycle(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic start(input logic [W-1:0] cnt, input logic [W-1:0] sa, input logic [W-1:0] ea);
        cycle(1'b1, cnt, sa, ea, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int lb_cnt;
        int err_cnt;
        logic [W-1:0] pc_r;

        bus.lc_start_i = 0; bus.lc_count_i = 0; bus.lc_start_addr_i = 0; bus.lc_end_addr_i = 0;
        bus.pc_i = 0; bus.pc_valid_i = 0; bus.lc_clear_i = 0;
        reset_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;
        peak_level = 0;

        // Reset state
        nop();
        check_val("reset_level", obs_level, 0);

        // Three-iteration loop over 0x10..0x14
        start(3, 16'h0010, 16'h0014);
        lb_cnt = 0;
        repeat (3) begin
            for (int a = 16'h10; a <= 16'h14; a++) begin
                fetch(W'(a));
                if (obs_loopb) lb_cnt++;
            end
        end
        fetch(16'h0015);
        check_val("loop3_loopbacks", lb_cnt, 2);
        check_val("loop3_level_after", obs_level, 0);

        // Zero count rejected
        start(0, 16'h0010, 16'h0014);
        check_val("zero_cnt_err", obs_err, 1);
        nop();
        check_val("zero_cnt_level", obs_level, 0);

        // Nested loops
        peak_level = 0;
        lb_cnt = 0;
        start(2, 16'h0020, 16'h0030);
        repeat (2) begin
            fetch(16'h0020);
            cycle(1'b1, 16'd2, 16'h0022, 16'h0024, 16'h0021, 1'b1, 1'b0, 1'b0);
            repeat (2) begin
                for (int a = 16'h22; a <= 16'h24; a++) begin
                    fetch(W'(a));
                    if (obs_loopb && a == 16'h24) lb_cnt++;
                end
            end
            for (int a = 16'h25; a <= 16'h30; a++) fetch(W'(a));
        end
        nop();
        check_val("nest_inner_loopbacks", lb_cnt, (DEPTH >= 2) ? 2 : 0);
        check_val("nest_peak_level", peak_level, (DEPTH >= 2) ? 2 : 1);
        check_val("nest_level_after", obs_level, 0);

        // Overflow: five starts
        err_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            start(5, W'(16'h0100 + i * 16), W'(16'h0108 + i * 16));
            if (obs_err) err_cnt++;
        end
        nop();
        check_val("overflow_errs", err_cnt, 5 - DEPTH);
        check_val("overflow_level", obs_level, DEPTH);
        cycle(1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        nop();
        check_val("overflow_cleared", obs_level, 0);

        // Pop and push in the same cycle
        start(1, 16'h0040, 16'h0042);
        fetch(16'h0040);
        fetch(16'h0041);
        cycle(1'b1, 16'd2, 16'h0050, 16'h0052, 16'h0042, 1'b1, 1'b0, 1'b0);
        nop();
        check_val("swap_level", obs_level, 1);
        check_val("swap_top_start", obs_pcl, 16'h0050);
        repeat (2) for (int a = 16'h50; a <= 16'h52; a++) fetch(W'(a));
        nop();
        check_val("swap_drained", obs_level, 0);

        // Clear mid-loop, then reset mid-loop on the end address with no valid fetch
        start(5, 16'h0060, 16'h0062);
        for (int a = 16'h60; a <= 16'h62; a++) fetch(W'(a));
        cycle(1'b0, '0, '0, '0, 16'h0061, 1'b1, 1'b1, 1'b0);
        fetch(16'h0062);
        check_val("clear_level", obs_level, 0);
        check_val("clear_loopb", obs_loopb, 0);
        start(5, 16'h0060, 16'h0062);
        fetch(16'h0060);
        fetch(16'h0061);
        cycle(1'b0, '0, '0, '0, 16'h0062, 1'b0, 1'b0, 1'b1);
        fetch(16'h0062);
        check_val("reset_mid_level", obs_level, 0);
        check_val("reset_mid_loopb", obs_loopb, 0);

        // Maximum count, single-instruction body
        start(16'hFFFF, 16'h0070, 16'h0070);
        repeat (4) fetch(16'h0070);
        check_val("maxcnt_loopb", obs_loopb, 1);
        check_val("maxcnt_target", obs_pcl, 16'h0070);
        cycle(1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0);

        // Random traffic
        pc_r = '0;
        for (int n = 0; n < 3000; n++) begin
            logic         st, pv, cl, rs;
            logic [W-1:0] cnt, sa, ea;
            st  = ($urandom % 8) == 0;
            cnt = (($urandom % 16) == 0) ? 16'hFFFF : W'($urandom_range(0, 4));
            sa  = W'($urandom_range(0, 15));
            ea  = sa + W'($urandom_range(0, 3));
            pv  = ($urandom % 5) != 0;
            cl  = ($urandom % 60) == 0;
            rs  = ($urandom % 250) == 0;
            cycle(st, cnt, sa, ea, pc_r, pv, cl, rs);
            if (pv) begin
                if (obs_loopb) pc_r = obs_pcl;
                else if (($urandom % 10) == 0) pc_r = W'($urandom_range(0, 19));
                else pc_r = (pc_r >= 19) ? '0 : pc_r + 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
